// File: rtl/divisor_seq_pkg.sv
// Shared types and helpers for the sequential signed divider.
package divisor_seq_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      ZERO = 2'd3
   } div_state_e;

   // Two's complement negate when neg is set; the magnitude of -2^(W-1) reads correctly as unsigned.
   function automatic logic [DIV_WIDTH-1:0] neg_if(input logic neg, input logic [DIV_WIDTH-1:0] x);
      return neg ? (~x + DIV_WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/divisor_seq_if.sv
// Start/done handshake plus operand and result buses between control and divider.
interface divisor_seq_if #(parameter int unsigned WIDTH = divisor_seq_pkg::DIV_WIDTH) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (output start, dividend, divisor,
                   input  lo, hi, busy, done, div_zero);

   modport slave  (input  start, dividend, divisor,
                   output lo, hi, busy, done, div_zero);

endinterface

// File: rtl/divisor_seq_div_step.sv
// One restoring division iteration on unsigned magnitudes.
module divisor_seq_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH:0]   dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic           fits;

   // The remainder stays below the divisor magnitude, so WIDTH bits always hold it.
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      fits    = (shifted >= dvs_i);
      rem_o   = fits ? WIDTH'(shifted - dvs_i) : shifted[WIDTH-1:0];
      quo_o   = {quo_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/divisor_seq.sv
// Sequential signed divider: quotient to lo, remainder to hi, MIPS div semantics.
module divisor_seq
   import divisor_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic         clock,
   input  logic         reset,
   divisor_seq_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] step_rem, step_quo;

   divisor_seq_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  state_d = ZERO;
               end else begin
                  quo_d     = neg_if(bus.dividend[WIDTH-1], bus.dividend);
                  dvs_d     = {1'b0, neg_if(bus.divisor[WIDTH-1], bus.divisor)};
                  rem_d     = '0;
                  neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  neg_rem_d = bus.dividend[WIDTH-1];
                  cnt_d     = CNT_W'(WIDTH);
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            busy_d = 1'b1;
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            lo_d    = neg_if(neg_quo_q, quo_q);
            hi_d    = neg_if(neg_rem_q, rem_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         ZERO: begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.lo       = lo_q;
   assign bus.hi       = hi_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS datapath.
- Consumes the A/B register outputs.
- Produces quotient for LO and remainder for HI through the HI/LO source muxes, under a start/done handshake from the control FSM.
- Flags division by zero so control can raise the exception path.

Parameters:
WIDTH, 32, operand/result width in bits; counter sized ceil(log2(WIDTH+1)).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; operands sampled on the same edge.
dividend  input  WIDTH  signed dividend (register A output).
divisor  input  WIDTH  signed divisor (register B output).
lo  output  WIDTH  quotient, registered.
hi  output  WIDTH  remainder, registered.
busy  output  1  high from the edge after start is accepted until the edge that raises done.
done  output  1  one-cycle completion pulse.
div_zero  output  1  one-cycle pulse coincident with done when divisor was 0.

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset).
- Reset, at any point including mid-operation:
  - state to IDLE.
  - lo, hi to 0.
  - busy, done, div_zero to 0.
  - counter and working registers cleared.
  - Any in-flight result is discarded.
- States: IDLE, RUN, FIX, ZERO.
- IDLE:
  - start=1 captures operands.
  - If divisor==0, go to ZERO.
  - Otherwise store |dividend| and |divisor| (two's complement magnitude in WIDTH+1 bits), remember sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), set count=WIDTH, clear partial remainder, go to RUN.
- RUN, one restoring step per edge:
  - Shift {rem, quo} left 1.
  - Trial-subtract the divisor magnitude.
  - If non-negative, keep the difference and set quo LSB=1; else restore and set quo LSB=0.
  - count decrements; at count==1 the transition goes to FIX.
- FIX:
  - lo <= sign_q ? -quo : quo.
  - hi <= sign_r ? -rem : rem.
  - Results truncated to WIDTH bits.
  - done=1 for that cycle; go to IDLE.
- ZERO: done=1 and div_zero=1 for one cycle; lo and hi keep their previous values; go to IDLE.
- Latency: start sampled at edge E0.
  - Normal division: done high in the cycle after edge E0+WIDTH+1, which is 33 edges for WIDTH=32.
  - Divide by zero: done high after E0+1.
- Semantics follow MIPS div: quotient truncates toward zero; remainder has the sign of the dividend.
- -2^31 / -1 wraps: lo=0x80000000, hi=0; no overflow flag.
- start while busy is ignored; operand changes during RUN are ignored.
- start in the cycle done is high is accepted normally (state is IDLE).
- lo and hi hold their last values until the next FIX or reset; they never show intermediate values.
- done and div_zero are never high except in the single completion cycle.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, RUN, FIX, ZERO).
  - The WIDTH default.
  - The counter width constant.
  - An abs/negate helper function.
- One natural sub-module, div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once and used each RUN cycle.
- FSM, sign handling and output registers stay in divisor_seq.

Test Plan:
- dividend=100, divisor=7, start pulse -> done exactly 33 cycles later; lo=14, hi=2, div_zero=0; busy high for 32 cycles.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); dividend=100, divisor=-7 -> lo=-14, hi=2.
- Previous result lo=14/hi=2; dividend=5, divisor=0 -> done and div_zero both high one cycle after start; lo=14, hi=2 unchanged; busy never high.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0. Also dividend=3, divisor=10 -> lo=0, hi=3.
- Start 100/7, assert reset 10 cycles later -> lo=hi=0, busy=0, no done pulse. Then start 50/5 -> lo=10, hi=0 after 33 cycles.
- Start 100/7, re-pulse start with 9/3 during RUN -> ignored, result 14/2. Start 9/3 in the done cycle -> accepted; lo=3, hi=0, 33 cycles later.
